// File: rtl/corevx_wb_pkg.sv
// Shared types and helpers for the CoreVX write-back arbiter.
package corevx_wb_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned XLEN       = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       wdata;
    } wb_req_t;

    // Round-robin successor of ptr in a ring of n entries.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr == n - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/corevx_rr_arbiter.sv
// Combinational round-robin arbiter; scanning starts at ptr and wraps modulo N.
module corevx_rr_arbiter #(
    parameter int unsigned N = 3
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx
);

    localparam int unsigned W = $clog2(N);

    int unsigned  idx;
    logic [W-1:0] sel;
    logic         found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        sel       = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= N) idx = idx - N;
            sel = W'(idx);
            if (!found && req[sel]) begin
                found      = 1'b1;
                grant[sel] = 1'b1;
                grant_idx  = sel;
            end
        end
    end

endmodule

// File: rtl/corevx_wb_arbiter.sv
// Round-robin write-back arbiter feeding a single registered regfile write port.
// Optional write-back forwarding to rs1/rs2 is enabled by defining COREVX_WB_FORWARD_EN.
module corevx_wb_arbiter
    import corevx_wb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*5-1:0]       req_addr,
    input  logic [NUM_REQ*32-1:0]      req_wdata,
    output logic [REG_ADDR_W-1:0]      rd_addr,
    output logic [XLEN-1:0]            rd_wdata,
    output logic                       rd_write,
    output logic [REG_ADDR_W-1:0]      wb_busy_addr,
    output logic                       wb_busy
`ifdef COREVX_WB_FORWARD_EN
    ,
    input  logic [REG_ADDR_W-1:0]      fwd_rs1_addr,
    input  logic [REG_ADDR_W-1:0]      fwd_rs2_addr,
    input  logic [XLEN-1:0]            rf_rs1_rdata,
    input  logic [XLEN-1:0]            rf_rs2_rdata,
    output logic [XLEN-1:0]            fwd_rs1_rdata,
    output logic [XLEN-1:0]            fwd_rs2_rdata
`endif
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] grant;
    logic               any_grant;
    logic               stage_valid;
    wb_req_t            stage_q;
    wb_req_t            winner;

    corevx_rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Grants are suppressed during reset so no requester sees a phantom accept.
    assign req_ready = rst_n ? grant : '0;
    assign any_grant = |req_ready;

    always_comb begin
        winner       = '0;
        winner.addr  = req_addr[grant_idx*REG_ADDR_W +: REG_ADDR_W];
        winner.wdata = req_wdata[grant_idx*XLEN +: XLEN];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            stage_valid <= 1'b0;
            stage_q     <= '0;
        end else begin
            stage_valid <= any_grant;
            if (any_grant) begin
                rr_ptr  <= PTR_W'(rr_next(32'(grant_idx), NUM_REQ));
                stage_q <= winner;
            end
        end
    end

    assign rd_write     = stage_valid && (stage_q.addr != '0);
    assign rd_addr      = stage_q.addr;
    assign rd_wdata     = stage_q.wdata;
    assign wb_busy      = rd_write;
    assign wb_busy_addr = stage_q.addr;

`ifdef COREVX_WB_FORWARD_EN
    // wb_busy is already false for x0, so x0 is never forwarded.
    assign fwd_rs1_rdata = (wb_busy && fwd_rs1_addr == wb_busy_addr) ? stage_q.wdata : rf_rs1_rdata;
    assign fwd_rs2_rdata = (wb_busy && fwd_rs2_addr == wb_busy_addr) ? stage_q.wdata : rf_rs2_rdata;
`endif

endmodule

// File: tb/tb_corevx_wb_arbiter.sv
// Directed self-checking bench for corevx_wb_arbiter with NUM_REQ=3 and a regfile stand-in.
module tb_corevx_wb_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   req_valid;
    logic [2:0]   req_ready;
    logic [14:0]  req_addr;
    logic [95:0]  req_wdata;
    logic [4:0]   rd_addr;
    logic [31:0]  rd_wdata;
    logic         rd_write;
    logic [4:0]   wb_busy_addr;
    logic         wb_busy;
`ifdef COREVX_WB_FORWARD_EN
    logic [4:0]   fwd_rs1_addr, fwd_rs2_addr;
    logic [31:0]  rf_rs1_rdata, rf_rs2_rdata;
    logic [31:0]  fwd_rs1_rdata, fwd_rs2_rdata;
`endif

    int total = 0;
    int bad   = 0;
    logic [31:0] rf [32];

    always #5 clk = ~clk;

    corevx_wb_arbiter #(.NUM_REQ(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rd_addr      (rd_addr),
        .rd_wdata     (rd_wdata),
        .rd_write     (rd_write),
        .wb_busy_addr (wb_busy_addr),
        .wb_busy      (wb_busy)
`ifdef COREVX_WB_FORWARD_EN
        ,
        .fwd_rs1_addr  (fwd_rs1_addr),
        .fwd_rs2_addr  (fwd_rs2_addr),
        .rf_rs1_rdata  (rf_rs1_rdata),
        .rf_rs2_rdata  (rf_rs2_rdata),
        .fwd_rs1_rdata (fwd_rs1_rdata),
        .fwd_rs2_rdata (fwd_rs2_rdata)
`endif
    );

    // Register file stand-in: written on the edge after the stage is loaded.
    always @(posedge clk) begin
        if (rd_write) rf[rd_addr] <= rd_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
        req_addr[i*5 +: 5]    = a;
        req_wdata[i*32 +: 32] = d;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        rst_n     = 1'b0;
        req_valid = 3'b111;
        req_addr  = '0;
        req_wdata = '0;
`ifdef COREVX_WB_FORWARD_EN
        fwd_rs1_addr = '0;
        fwd_rs2_addr = '0;
        rf_rs1_rdata = '0;
        rf_rs2_rdata = '0;
`endif
        #3;
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_write", 32'(rd_write), 32'h0);
        check("rst_addr", 32'(rd_addr), 32'h0);
        check("rst_wdata", rd_wdata, 32'h0);
        check("rst_busy", 32'(wb_busy), 32'h0);
        check("rst_busy_addr", 32'(wb_busy_addr), 32'h0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Reset asserted right after acceptance discards the staged write
        set_req(0, 5'd5, 32'hDEADBEEF);
        req_valid = 3'b001;
        #1;
        check("midrst_ready", 32'(req_ready), 32'h1);
        step();
        rst_n     = 1'b0;
        req_valid = '0;
        #1;
        check("midrst_write", 32'(rd_write), 32'h0);
        check("midrst_addr", 32'(rd_addr), 32'h0);
        check("midrst_wdata", rd_wdata, 32'h0);
        check("midrst_busy", 32'(wb_busy), 32'h0);
        step();
        check("midrst_rf5", rf[5], 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Single requester
        set_req(1, 5'd7, 32'h12345678);
        req_valid = 3'b010;
        #1;
        check("single_ready", 32'(req_ready), 32'h2);
        step();
        req_valid = '0;
        check("single_write", 32'(rd_write), 32'h1);
        check("single_addr", 32'(rd_addr), 32'd7);
        check("single_wdata", rd_wdata, 32'h12345678);
        check("single_busy", 32'(wb_busy), 32'h1);
        check("single_busy_addr", 32'(wb_busy_addr), 32'd7);
        step();
        check("single_rf7", rf[7], 32'h12345678);
        check("single_idle_write", 32'(rd_write), 32'h0);

        // x0 request from req2 (pointer is at 2 here)
        set_req(2, 5'd0, 32'hFFFFFFFF);
        req_valid = 3'b100;
        #1;
        check("x0_ready", 32'(req_ready), 32'h4);
        step();
        req_valid = '0;
        check("x0_write", 32'(rd_write), 32'h0);
        check("x0_busy", 32'(wb_busy), 32'h0);
        check("x0_wdata", rd_wdata, 32'hFFFFFFFF);

        // All three valid: pointer wrapped to 0, so grants go 0,1,2,0,1,2
        set_req(0, 5'd10, 32'hA0A0A0A0);
        set_req(1, 5'd11, 32'hB1B1B1B1);
        set_req(2, 5'd12, 32'hC2C2C2C2);
        req_valid = 3'b111;
        for (int r = 0; r < 6; r++) begin
            #1;
            check($sformatf("rr_ready%0d", r), 32'(req_ready), 32'(1 << (r % 3)));
            step();
            check($sformatf("rr_write%0d", r), 32'(rd_write), 32'h1);
            check($sformatf("rr_addr%0d", r), 32'(rd_addr), 32'(10 + r % 3));
        end
        req_valid = '0;
        step();
        check("rr_rf10", rf[10], 32'hA0A0A0A0);
        check("rr_rf11", rf[11], 32'hB1B1B1B1);
        check("rr_rf12", rf[12], 32'hC2C2C2C2);

        // Same-rd collision: req1 is granted last and its value sticks
        set_req(0, 5'd3, 32'h1);
        set_req(1, 5'd3, 32'h2);
        req_valid = 3'b011;
        #1;
        check("coll_ready0", 32'(req_ready), 32'h1);
        step();
        req_valid = 3'b010;
        #1;
        check("coll_ready1", 32'(req_ready), 32'h2);
        step();
        req_valid = '0;
        step();
        check("coll_rf3", rf[3], 32'h2);

`ifdef COREVX_WB_FORWARD_EN
        set_req(0, 5'd9, 32'hA5A5A5A5);
        req_valid = 3'b001;
        step();
        req_valid    = '0;
        fwd_rs1_addr = 5'd9;
        rf_rs1_rdata = 32'h0;
        fwd_rs2_addr = 5'd0;
        rf_rs2_rdata = 32'h13572468;
        #1;
        check("fwd_rs1", fwd_rs1_rdata, 32'hA5A5A5A5);
        check("fwd_rs2", fwd_rs2_rdata, 32'h13572468);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
